// File: rtl/fuzzy_pkg.sv
// Shared types and corner-address helpers for the interval type-2 trapezoidal fuzzifier.
package fuzzy_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, DIV, WB, COMMIT} state_t;
  typedef enum logic [1:0] {ZERO, RISE, PLATEAU, FALL} region_t;

  localparam int SET_UP          = 0;
  localparam int SET_LOW         = 1;
  localparam int CORNER_A        = 0;
  localparam int CORNER_B        = 1;
  localparam int CORNER_C        = 2;
  localparam int CORNER_D        = 3;
  localparam int CORNERS_PER_SET = 4;
  localparam int SETS_PER_MF     = 2;

  // Flat corner index of MF mf (= input*N_MF + j), set (UP/LOW) and corner (A..D).
  function automatic int f_cfg_idx(input int mf, input int set, input int corner);
    return (mf * SETS_PER_MF + set) * CORNERS_PER_SET + corner;
  endfunction

endpackage

// File: rtl/divisor_restaurador.sv
// Sequential restoring divider: 2W-bit numerator / W-bit denominator, one quotient bit per cycle.
module divisor_restaurador #(
  parameter int W = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic [2*W-1:0] i_num,
  input  logic [W-1:0]   i_den,
  output logic           o_valid,
  output logic [W-1:0]   o_quo
);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_quo;
  logic [W-1:0]  r_den;
  logic [CW-1:0] r_cnt;
  logic          r_run;
  logic [W:0]    w_shift;
  logic [W-1:0]  w_diff;
  logic          w_ge;

  // The quotient fits in W bits, so the high numerator half seeds the remainder directly.
  assign w_shift = {r_rem, r_quo[W-1]};
  assign w_ge    = (w_shift >= {1'b0, r_den});
  assign w_diff  = w_shift[W-1:0] - r_den;

  // High during the final iteration; o_quo holds the finished quotient after that edge.
  assign o_valid = r_run && (r_cnt == CW'(W - 1));
  assign o_quo   = r_quo;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rem <= '0;
      r_quo <= '0;
      r_den <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_start) begin
      r_rem <= i_num[2*W-1:W];
      r_quo <= i_num[W-1:0];
      r_den <= i_den;
      r_cnt <= '0;
      r_run <= 1'b1;
    end else if (r_run) begin
      r_rem <= w_ge ? w_diff : w_shift[W-1:0];
      r_quo <= {r_quo[W-2:0], w_ge};
      r_cnt <= r_cnt + CW'(1);
      if (r_cnt == CW'(W - 1)) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/bloco_fuzzificador_it2.sv
// Time-multiplexed IT2 trapezoidal fuzzifier: evaluates every UP/LOW degree through one shared divider.
module bloco_fuzzificador_it2
  import fuzzy_pkg::*;
#(
  parameter  int W    = 8,
  parameter  int N_IN = 2,
  parameter  int N_MF = 3,
  localparam int M    = N_IN * N_MF,
  localparam int AW   = $clog2(8 * M)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [N_IN*W-1:0] i_inputs,
  input  logic              i_cfg_we,
  input  logic [AW-1:0]     i_cfg_addr,
  input  logic [W-1:0]      i_cfg_data,
  output logic [M*W-1:0]    o_mu_up,
  output logic [M*W-1:0]    o_mu_low,
  output logic [M-1:0]      o_ativo_up,
  output logic              o_busy,
  output logic              o_done,
  output state_t            o_dbg_state
);
  localparam int             NC   = 8 * M;
  localparam int             NE   = 2 * M;
  localparam int             EW   = (NE > 1) ? $clog2(NE) : 1;
  localparam logic [2*W-1:0] MAX2 = {{W{1'b0}}, {W{1'b1}}};
  localparam logic [W-1:0]   MAX  = '1;

  // Valid/ready: i_start is accepted only while o_busy is low; o_done marks one cycle of fresh results.
  state_t              r_state;
  region_t             r_region;
  logic [EW-1:0]       r_e;
  logic [N_IN*W-1:0]   r_x;
  logic [W-1:0]        r_corner [NC];
  logic [W-1:0]        r_sh_up  [M];
  logic [W-1:0]        r_sh_low [M];
  logic [M*W-1:0]      r_mu_up;
  logic [M*W-1:0]      r_mu_low;
  logic [M-1:0]        r_ativo;
  logic                r_busy;
  logic                r_done;

  int                  w_in_idx;
  logic [AW-1:0]       w_base;
  logic [W-1:0]        w_x, w_a, w_b, w_c, w_d, w_den, w_quo, w_wb_val;
  logic [2*W-1:0]      w_num;
  region_t             w_region;
  logic                w_div_start;
  logic                w_div_valid;

  // Evaluation e = 2*m + s maps straight onto corner words 4*e .. 4*e+3.
  always_comb begin
    w_in_idx = int'(r_e) / (2 * N_MF);
    w_x      = '0;
    for (int i = 0; i < N_IN; i++)
      if (w_in_idx == i) w_x = r_x[i*W +: W];
    w_base   = AW'(f_cfg_idx(int'(r_e) >> 1, int'(r_e[0]), CORNER_A));
    w_a      = r_corner[w_base + AW'(CORNER_A)];
    w_b      = r_corner[w_base + AW'(CORNER_B)];
    w_c      = r_corner[w_base + AW'(CORNER_C)];
    w_d      = r_corner[w_base + AW'(CORNER_D)];
    w_region = ZERO;
    w_num    = '0;
    w_den    = W'(1);
    if (w_x < w_a || w_x > w_d) begin
      w_region = ZERO;
    end else if (w_x >= w_b && w_x <= w_c) begin
      w_region = PLATEAU;
    end else if (w_x < w_b) begin
      w_region = RISE;
      w_num    = {{W{1'b0}}, W'(w_x - w_a)} * MAX2;
      w_den    = w_b - w_a;
    end else begin
      w_region = FALL;
      w_num    = {{W{1'b0}}, W'(w_d - w_x)} * MAX2;
      w_den    = w_d - w_c;
    end
  end

  always_comb begin
    case (r_region)
      PLATEAU:    w_wb_val = MAX;
      RISE, FALL: w_wb_val = w_quo;
      default:    w_wb_val = '0;
    endcase
  end

  assign w_div_start = (r_state == SETUP);

  divisor_restaurador #(.W(W)) u_div (
    .i_clk   (i_clk),
    .i_rst   (i_reset),
    .i_start (w_div_start),
    .i_num   (w_num),
    .i_den   (w_den),
    .o_valid (w_div_valid),
    .o_quo   (w_quo)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_region <= ZERO;
      r_e      <= '0;
      r_x      <= '0;
      r_mu_up  <= '0;
      r_mu_low <= '0;
      r_ativo  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      for (int n = 0; n < NC; n++) r_corner[n] <= '0;
      for (int m = 0; m < M; m++) begin
        r_sh_up[m]  <= '0;
        r_sh_low[m] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_cfg_we && int'(i_cfg_addr) < NC) r_corner[i_cfg_addr] <= i_cfg_data;
          if (i_start) begin
            r_x     <= i_inputs;
            r_e     <= '0;
            r_busy  <= 1'b1;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          r_region <= w_region;
          r_state  <= DIV;
        end
        DIV: begin
          if (w_div_valid) r_state <= WB;
        end
        WB: begin
          for (int m = 0; m < M; m++)
            if (int'(r_e >> 1) == m) begin
              if (r_e[0]) r_sh_low[m] <= w_wb_val;
              else        r_sh_up[m]  <= w_wb_val;
            end
          if (r_e == EW'(NE - 1)) begin
            r_state <= COMMIT;
          end else begin
            r_e     <= r_e + EW'(1);
            r_state <= SETUP;
          end
        end
        COMMIT: begin
          // The lower degree may never exceed the upper one.
          for (int m = 0; m < M; m++) begin
            r_mu_up[m*W +: W]  <= r_sh_up[m];
            r_mu_low[m*W +: W] <= (r_sh_low[m] < r_sh_up[m]) ? r_sh_low[m] : r_sh_up[m];
            r_ativo[m]         <= |r_sh_up[m];
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_mu_up     = r_mu_up;
  assign o_mu_low    = r_mu_low;
  assign o_ativo_up  = r_ativo;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bloco_fuzzificador_it2.sv
// Directed bench for bloco_fuzzificador_it2: default build plus a W=10, 3x5 build for the sweep.
module tb_bloco_fuzzificador_it2;
  import fuzzy_pkg::*;

  localparam int W   = 8;
  localparam int M   = 6;
  localparam int AW  = 6;
  localparam int T   = 2 * M * (W + 2);
  localparam int W2  = 10;
  localparam int M2  = 15;
  localparam int AW2 = 7;
  localparam int T2  = 2 * M2 * (W2 + 2);

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            start = 1'b0;
  logic [2*W-1:0]  inputs = '0;
  logic            cfg_we = 1'b0;
  logic [AW-1:0]   cfg_addr = '0;
  logic [W-1:0]    cfg_data = '0;
  logic [M*W-1:0]  mu_up, mu_low;
  logic [M-1:0]    ativo;
  logic            busy, done;
  state_t          st;

  logic            start_b = 1'b0;
  logic [3*W2-1:0] inputs_b = '0;
  logic            cfg_we_b = 1'b0;
  logic [AW2-1:0]  cfg_addr_b = '0;
  logic [W2-1:0]   cfg_data_b = '0;
  logic [M2*W2-1:0] mu_up_b, mu_low_b;
  logic [M2-1:0]   ativo_b;
  logic            busy_b, done_b;
  state_t          st_b;

  bloco_fuzzificador_it2 dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_inputs(inputs),
    .i_cfg_we(cfg_we), .i_cfg_addr(cfg_addr), .i_cfg_data(cfg_data),
    .o_mu_up(mu_up), .o_mu_low(mu_low), .o_ativo_up(ativo),
    .o_busy(busy), .o_done(done), .o_dbg_state(st)
  );

  bloco_fuzzificador_it2 #(.W(W2), .N_IN(3), .N_MF(5)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_start(start_b), .i_inputs(inputs_b),
    .i_cfg_we(cfg_we_b), .i_cfg_addr(cfg_addr_b), .i_cfg_data(cfg_data_b),
    .o_mu_up(mu_up_b), .o_mu_low(mu_low_b), .o_ativo_up(ativo_b),
    .o_busy(busy_b), .o_done(done_b), .o_dbg_state(st_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int a, input logic [W-1:0] d);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic load_set(input int m, input int s, input int a, input int b, input int c, input int d);
    int base;
    base = (m * 2 + s) * 4;
    cfg_write(base + 0, W'(a));
    cfg_write(base + 1, W'(b));
    cfg_write(base + 2, W'(c));
    cfg_write(base + 3, W'(d));
  endtask

  task automatic cfg_write_b(input int a, input int d);
    cfg_we_b = 1'b1; cfg_addr_b = AW2'(a); cfg_data_b = W2'(d);
    tick();
    cfg_we_b = 1'b0;
  endtask

  // Scoreboard: expected upper degrees for MF 0..5, then lower degrees.
  task automatic push_exp(input logic [M*W-1:0] up, input logic [M*W-1:0] low);
    for (int m = 0; m < M; m++) exp_q.push_back(up[m*W +: W]);
    for (int m = 0; m < M; m++) exp_q.push_back(low[m*W +: W]);
  endtask

  task automatic check_outputs(input string tag);
    for (int m = 0; m < M; m++) check($sformatf("%s_up%0d", tag, m), 64'(mu_up[m*W +: W]), 64'(exp_q.pop_front()));
    for (int m = 0; m < M; m++) check($sformatf("%s_low%0d", tag, m), 64'(mu_low[m*W +: W]), 64'(exp_q.pop_front()));
  endtask

  // Starts an evaluation, optionally disturbs it while busy, and waits (bounded) for DONE.
  task automatic run_eval(input string tag, input logic [2*W-1:0] x, input bit disturb,
                          input bit same_cfg, input int ca, input logic [W-1:0] cd,
                          input logic [M*W-1:0] hold);
    int lat;
    int nd;
    inputs = x;
    start  = 1'b1;
    if (same_cfg) begin
      cfg_we = 1'b1; cfg_addr = AW'(ca); cfg_data = cd;
    end
    tick();
    start  = 1'b0;
    cfg_we = 1'b0;
    check({tag, "_busy_t0"}, 64'(busy), 64'd1);
    lat = 0;
    while (!done && lat < T + 20) begin
      tick();
      lat++;
      if (disturb) begin
        if (lat == 20) begin
          start = 1'b1; inputs = '1;
          cfg_we = 1'b1; cfg_addr = AW'(3); cfg_data = 8'd200;
        end else if (lat == 21) begin
          start = 1'b0; cfg_we = 1'b0; inputs = '0;
        end else if (lat == 22) start = 1'b1;
        else if (lat == 23) start = 1'b0;
        if (lat == 60) check({tag, "_hold"}, 64'(mu_up), 64'(hold));
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'(T + 1));
    check({tag, "_busy_done"}, 64'(busy), 64'd0);
    nd = 0;
    repeat (6) begin
      tick();
      if (done) nd++;
    end
    check({tag, "_one_done"}, 64'(nd), 64'd0);
  endtask

  task automatic run_eval_b(input string tag, input logic [3*W2-1:0] x);
    int lat;
    inputs_b = x;
    start_b  = 1'b1;
    tick();
    start_b  = 1'b0;
    lat = 0;
    while (!done_b && lat < T2 + 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(T2 + 1));
  endtask

  localparam logic [M*W-1:0] ALL_MAX = '1;
  localparam logic [M*W-1:0] UP_S2   = {8'd255, 8'd255, 8'd255, 8'd0, 8'd255, 8'd137};
  localparam logic [M*W-1:0] LOW_S2  = {8'd255, 8'd255, 8'd255, 8'd0, 8'd255, 8'd122};
  localparam logic [M*W-1:0] UP_CL   = {8'd255, 8'd255, 8'd255, 8'd0, 8'd255, 8'd122};

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_mu_up", 64'(mu_up), 64'd0);
    check("rst_mu_low", 64'(mu_low), 64'd0);
    check("rst_ativo", 64'(ativo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_state", 64'(st), 64'(IDLE));

    // zero corners: x=0 sits on the degenerate plateau, x=7 is outside it
    push_exp(ALL_MAX, ALL_MAX);
    run_eval("zero0", 16'h0000, 1'b0, 1'b0, 0, 8'd0, '0);
    check_outputs("zero0");
    check("zero0_ativo", 64'(ativo), 64'h3F);
    push_exp('0, '0);
    run_eval("zero7", {8'd7, 8'd7}, 1'b0, 1'b0, 0, 8'd0, '0);
    check_outputs("zero7");
    check("zero7_ativo", 64'(ativo), 64'h00);

    // input-0 trapezoids, x0=80 (fall, plateau, zero), x1=0 on zero corners
    load_set(0, 0, 0, 1, 51, 114);    load_set(0, 1, 0, 1, 51, 107);
    load_set(1, 0, 5, 77, 153, 222);  load_set(1, 1, 18, 77, 153, 209);
    load_set(2, 0, 118, 179, 254, 255); load_set(2, 1, 125, 179, 254, 255);
    push_exp(UP_S2, LOW_S2);
    run_eval("trap", {8'd0, 8'd80}, 1'b0, 1'b0, 0, 8'd0, '0);
    check_outputs("trap");
    check("trap_ativo", 64'(ativo), 64'b111011);

    // start, corner write and input changes while busy must all be ignored
    push_exp(UP_S2, LOW_S2);
    run_eval("busy", {8'd0, 8'd80}, 1'b1, 1'b0, 0, 8'd0, UP_S2);
    check_outputs("busy");
    push_exp(UP_S2, LOW_S2);
    run_eval("busy_cfg", {8'd0, 8'd80}, 1'b0, 1'b0, 0, 8'd0, '0);
    check_outputs("busy_cfg");

    // lower trapezoid wider than upper: raw LOW 137 clamped to UP 122
    load_set(0, 0, 0, 1, 51, 107);
    load_set(0, 1, 0, 1, 51, 114);
    push_exp(UP_CL, UP_CL);
    run_eval("clamp", {8'd0, 8'd80}, 1'b0, 1'b0, 0, 8'd0, '0);
    check_outputs("clamp");

    // corner write in the START cycle is used: UP D back to 114
    push_exp(UP_S2, UP_S2);
    run_eval("same", {8'd0, 8'd80}, 1'b0, 1'b1, 3, 8'd114, '0);
    check_outputs("same");
    check("same_ativo", 64'(ativo), 64'b111011);

    // asynchronous reset in the middle of an evaluation
    begin
      int nd;
      inputs = '0;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      repeat (49) tick();
      #2 rst = 1'b1;
      #1;
      check("arst_mu_up", 64'(mu_up), 64'd0);
      check("arst_mu_low", 64'(mu_low), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_done", 64'(done), 64'd0);
      #1 rst = 1'b0;
      nd = 0;
      repeat (T + 10) begin
        tick();
        if (done) nd++;
      end
      check("arst_no_done", 64'(nd), 64'd0);
    end
    push_exp(ALL_MAX, ALL_MAX);
    run_eval("post_rst", 16'h0000, 1'b0, 1'b0, 0, 8'd0, '0);
    check_outputs("post_rst");
    check("post_rst_ativo", 64'(ativo), 64'h3F);

    // W=10, 3 inputs x 5 MFs: MF0 of every input uses (100,200,300,400)
    for (int i = 0; i < 3; i++) begin
      cfg_write_b(40 * i + 0, 100);
      cfg_write_b(40 * i + 1, 200);
      cfg_write_b(40 * i + 2, 300);
      cfg_write_b(40 * i + 3, 400);
    end
    run_eval_b("sw1", {10'd300, 10'd200, 10'd100});
    check("sw1_x_eq_a", 64'(mu_up_b[0 +: W2]), 64'd0);
    check("sw1_x_eq_b", 64'(mu_up_b[50 +: W2]), 64'd1023);
    check("sw1_x_eq_c", 64'(mu_up_b[100 +: W2]), 64'd1023);
    check("sw1_low", 64'(|mu_low_b), 64'd0);
    check("sw1_ativo", 64'(ativo_b), 64'h0420);
    run_eval_b("sw2", {10'd350, 10'd150, 10'd400});
    check("sw2_x_eq_d", 64'(mu_up_b[0 +: W2]), 64'd0);
    check("sw2_rise", 64'(mu_up_b[50 +: W2]), 64'd511);
    check("sw2_fall", 64'(mu_up_b[100 +: W2]), 64'd511);
    check("sw2_ativo", 64'(ativo_b), 64'h0420);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
